// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision adder datapath.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] fraction;
  } fp32_t;

  localparam fp32_t FP_QNAN    = '{sign: 1'b0, exponent: EXP_MAX, fraction: 23'h400000};
  localparam fp32_t FP_POS_INF = '{sign: 1'b0, exponent: EXP_MAX, fraction: 23'h000000};
  localparam fp32_t FP_NEG_INF = '{sign: 1'b1, exponent: EXP_MAX, fraction: 23'h000000};

  function automatic fp32_t fp_inf(input logic sign);
    return '{sign: sign, exponent: EXP_MAX, fraction: 23'h000000};
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the single-cycle normalization path.
// Compiled only when FPNR_FAST_LZC_EN is defined.
`ifdef FPNR_FAST_LZC_EN
module fp_lzc #(
  parameter int W     = 25,
  parameter int CNT_W = 5
) (
  input  logic [W-1:0]     vec_i,
  output logic [CNT_W-1:0] count_o
);
  // Ascending scan: the highest set bit is visited last and wins.
  always_comb begin
    count_o = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      count_o = vec_i[i] ? CNT_W'(W - 1 - i) : count_o;
    end
  end
endmodule
`endif

// File: rtl/fp_normalize_round.sv
// Normalize, round-to-nearest-even and pack back end of the FP adder.
// Define FPNR_FAST_LZC_EN to normalize in one cycle through fp_lzc.
module fp_normalize_round #(
  parameter int SHIFT_STEP = 1,
  parameter int EXP_W      = 8,
  parameter int MANT_W     = 23
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exponent,
  input  logic [MANT_W+1:0]         in_sum,
  input  logic                      in_guard,
  input  logic                      in_round,
  input  logic                      in_sticky,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W:0]     out_result,
  output logic                      out_overflow,
  output logic                      out_underflow,
  output logic                      out_inexact
);
  import fp_pkg::*;

  localparam int SUM_W = MANT_W + 2;
  localparam int SHV_W = SUM_W + 2;
  localparam int CNT_W = $clog2(SUM_W + 1);
  localparam int RES_W = EXP_W + MANT_W + 1;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   mant_q, mant_d;
  logic               g_q, g_d, r_q, r_d, s_q, s_d, sign_q, sign_d;
  logic [EXP_W:0]     exp_q, exp_d;
  logic               out_valid_q, out_valid_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  logic [SHV_W-1:0]   shv_s;
  logic [CNT_W-1:0]   lshift_n_s;
  logic               in_zero_s, norm_unf_s, roundup_s, rnd_carry_s;
  logic [SUM_W-1:0]   frac_sum_s;
  logic [EXP_W:0]     exp_rnd_s;

  assign shv_s     = {mant_q, g_q, r_q};
  assign in_zero_s = (in_sum == '0) && !(in_guard | in_round | in_sticky);

`ifdef FPNR_FAST_LZC_EN
  localparam state_t LSHIFT_NEXT = ROUND;

  fp_lzc #(
    .W     (SUM_W),
    .CNT_W (CNT_W)
  ) u_lzc (
    .vec_i   ({mant_q[SUM_W-2:0], g_q}),
    .count_o (lshift_n_s)
  );
`else
  localparam state_t LSHIFT_NEXT = NORM;

  // Distance to the leading one, capped at SHIFT_STEP; bit 23 is already known 0.
  always_comb begin
    lshift_n_s = CNT_W'(SHIFT_STEP);
    for (int i = SHIFT_STEP - 1; i >= 1; i--) begin
      lshift_n_s = shv_s[SHV_W-2-i] ? CNT_W'(i) : lshift_n_s;
    end
  end
`endif

  // An all-zero {mant,g,r} can never normalize, so it flushes like an exponent underflow.
  assign norm_unf_s  = (shv_s == '0) || (exp_q <= (EXP_W+1)'(lshift_n_s));
  assign roundup_s   = g_q & (r_q | s_q | mant_q[0]);
  assign frac_sum_s  = {1'b0, mant_q[SUM_W-2:0]} + SUM_W'(roundup_s);
  assign rnd_carry_s = frac_sum_s[SUM_W-1];
  assign exp_rnd_s   = exp_q + (EXP_W+1)'(rnd_carry_s);

  // State register and working/result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      g_q         <= g_d;
      r_q         <= r_d;
      s_q         <= s_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = in_valid ? (in_zero_s ? HOLD : NORM) : IDLE;
      NORM: begin
        if (mant_q[SUM_W-1] || mant_q[SUM_W-2]) begin
          state_d = ROUND;
        end else if (norm_unf_s) begin
          state_d = HOLD;
        end else begin
          state_d = LSHIFT_NEXT;
        end
      end
      ROUND: state_d = HOLD;
      HOLD:  state_d = (out_valid_q && out_ready) ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and result loading.
  always_comb begin
    mant_d      = mant_q;
    g_d         = g_q;
    r_d         = r_q;
    s_d         = s_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d = in_sum;
          g_d    = in_guard;
          r_d    = in_round;
          s_d    = in_sticky;
          sign_d = in_sign;
          exp_d  = {1'b0, in_exponent};
          if (in_zero_s) begin
            result_d    = '0;
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
            inx_d       = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b0;
          end
        end else begin
          out_valid_d = 1'b0;
        end
      end
      NORM: begin
        if (mant_q[SUM_W-1]) begin
          mant_d = mant_q >> 1;
          g_d    = mant_q[0];
          r_d    = g_q;
          s_d    = s_q | r_q;
          exp_d  = exp_q + {{EXP_W{1'b0}}, 1'b1};
        end else if (mant_q[SUM_W-2]) begin
          mant_d = mant_q;
        end else if (norm_unf_s) begin
          result_d    = {sign_q, {(RES_W-1){1'b0}}};
          ovf_d       = 1'b0;
          unf_d       = 1'b1;
          inx_d       = g_q | r_q | s_q;
          out_valid_d = 1'b1;
        end else begin
          {mant_d, g_d, r_d} = shv_s << lshift_n_s;
          exp_d              = exp_q - (EXP_W+1)'(lshift_n_s);
        end
      end
      ROUND: begin
        exp_d       = exp_rnd_s;
        unf_d       = 1'b0;
        inx_d       = g_q | r_q | s_q;
        out_valid_d = 1'b1;
        if (exp_rnd_s >= {1'b0, {EXP_W{1'b1}}}) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd_s[EXP_W-1:0],
                      (rnd_carry_s ? {MANT_W{1'b0}} : frac_sum_s[MANT_W-1:0])};
          ovf_d    = 1'b0;
        end
      end
      HOLD: out_valid_d = out_ready ? 1'b0 : 1'b1;
      default: out_valid_d = 1'b0;
    endcase
  end

  // Output drive.
  always_comb begin
    in_ready      = (state_q == IDLE);
    out_valid     = out_valid_q;
    out_result    = result_q;
    out_overflow  = ovf_q;
    out_underflow = unf_q;
    out_inexact   = inx_q;
  end
endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round: expected results are queued at
// issue time and compared when the result handshake completes.
module tb_fp_normalize_round;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sign, in_guard, in_round, in_sticky;
  logic [7:0]  in_exponent;
  logic [24:0] in_sum;
  logic        out_valid, out_ready, out_overflow, out_underflow, out_inexact;
  logic [31:0] out_result;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int          accept_t;
  logic [31:0] obs_res;
  logic        obs_ovf, obs_unf, obs_inx, obs_ok;
  int          obs_lat;

`ifdef FPNR_FAST_LZC_EN
  localparam int CANCEL_LAT = 3;
`else
  localparam int CANCEL_LAT = 26;
`endif

  fp_normalize_round #(.SHIFT_STEP(1), .EXP_W(8), .MANT_W(23)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exponent   (in_exponent),
    .in_sum        (in_sum),
    .in_guard      (in_guard),
    .in_round      (in_round),
    .in_sticky     (in_sticky),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_op(input logic sg, input logic [7:0] ex, input logic [24:0] sm,
                          input logic g, input logic r, input logic s);
    int waited;
    waited      = 0;
    in_sign     = sg;
    in_exponent = ex;
    in_sum      = sm;
    in_guard    = g;
    in_round    = r;
    in_sticky   = s;
    in_valid    = 1'b1;
    while (in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    accept_t = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    obs_ok  = (out_valid === 1'b1);
    obs_res = out_result;
    obs_ovf = out_overflow;
    obs_unf = out_underflow;
    obs_inx = out_inexact;
    obs_lat = cyc + 1 - accept_t;
  endtask

  task automatic run_op(input exp_t e, input logic sg, input logic [7:0] ex,
                        input logic [24:0] sm, input logic g, input logic r, input logic s);
    sb_q.push_back(e);
    drive_op(sg, ex, sm, g, r, s);
    wait_out(200);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_result !== 32'h0 || {out_overflow, out_underflow, out_inexact} !== 3'b000) begin
      errors++;
      $display("FAIL reset_out: result=%h flags=%b required 0/000", out_result,
               {out_overflow, out_underflow, out_inexact});
    end
  endtask

  task automatic test_table(input string name, input int first, input int count);
    exp_t        tbl_e [7];
    logic [24:0] tbl_sum [7];
    logic [7:0]  tbl_exp [7];
    logic [3:0]  tbl_sgrs [7];
    exp_t        e;
    tbl_e[0] = '{32'h40000000, 1'b0, 1'b0, 1'b0, 3};          tbl_sum[0] = 25'h1000000;
    tbl_exp[0] = 8'd127; tbl_sgrs[0] = 4'b0000;
    tbl_e[1] = '{32'h34000000, 1'b0, 1'b0, 1'b0, CANCEL_LAT}; tbl_sum[1] = 25'h0000001;
    tbl_exp[1] = 8'd127; tbl_sgrs[1] = 4'b0000;
    tbl_e[2] = '{32'h00000000, 1'b0, 1'b1, 1'b0, 0};          tbl_sum[2] = 25'h0000001;
    tbl_exp[2] = 8'd10;  tbl_sgrs[2] = 4'b0000;
    tbl_e[3] = '{32'h3F800002, 1'b0, 1'b0, 1'b1, 3};          tbl_sum[3] = 25'h0800001;
    tbl_exp[3] = 8'd127; tbl_sgrs[3] = 4'b0100;
    tbl_e[4] = '{32'h3F800000, 1'b0, 1'b0, 1'b1, 3};          tbl_sum[4] = 25'h0800000;
    tbl_exp[4] = 8'd127; tbl_sgrs[4] = 4'b0100;
    tbl_e[5] = '{32'hFF800000, 1'b1, 1'b0, 1'b1, 3};          tbl_sum[5] = 25'h1FFFFFF;
    tbl_exp[5] = 8'd254; tbl_sgrs[5] = 4'b1100;
    tbl_e[6] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 1};          tbl_sum[6] = 25'h0000000;
    tbl_exp[6] = 8'd127; tbl_sgrs[6] = 4'b1000;
    for (int i = first; i < first + count; i++) begin
      run_op(tbl_e[i], tbl_sgrs[i][3], tbl_exp[i], tbl_sum[i], tbl_sgrs[i][2], tbl_sgrs[i][1],
             tbl_sgrs[i][0]);
      e = sb_q.pop_front();
      checks++;
      if (!obs_ok) begin
        errors++;
        $display("FAIL %s_valid[%0d]: out_valid=0 after budget, required 1", name, i);
      end
      checks++;
      if (obs_res !== e.res) begin
        errors++;
        $display("FAIL %s_result[%0d]: got %h required %h", name, i, obs_res, e.res);
      end
      checks++;
      if ({obs_ovf, obs_unf, obs_inx} !== {e.ovf, e.unf, e.inx}) begin
        errors++;
        $display("FAIL %s_flags[%0d]: ovf/unf/inx got %b required %b", name, i,
                 {obs_ovf, obs_unf, obs_inx}, {e.ovf, e.unf, e.inx});
      end
      if (e.lat > 0) begin
        checks++;
        if (obs_lat != e.lat) begin
          errors++;
          $display("FAIL %s_latency[%0d]: got %0d required %0d", name, i, obs_lat, e.lat);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    sb_q.push_back('{32'h3F800000, 1'b0, 1'b0, 1'b1, 3});
    drive_op(1'b0, 8'd127, 25'h0800000, 1'b1, 1'b0, 1'b0);
    wait_out(200);
    e = sb_q.pop_front();
    checks++;
    if (!obs_ok || obs_res !== e.res) begin
      errors++;
      $display("FAIL bp_result: valid=%b result=%h required 1/%h", obs_ok, obs_res, e.res);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_result !== e.res || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall[%0d]: result=%h valid=%b in_ready=%b required %h/1/0",
                 i, out_result, out_valid, in_ready, e.res);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== e.res || out_inexact !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b in_ready=%b result=%h inexact=%b required 0/1/%h/1",
               out_valid, in_ready, out_result, out_inexact, e.res);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    drive_op(1'b0, 8'd127, 25'h0000001, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_now: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_discard: out_valid seen=%b in_ready=%b required 0/1", seen, in_ready);
    end
    test_table("after_reset", 0, 1);
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [22:0] frac;
    logic [24:0] f;
    logic [7:0]  e8;
    logic        sg, g, r, s, ru;
    for (int i = 0; i < 6; i++) begin
      frac = (i == 0) ? 23'h7FFFFF : 23'($urandom_range(0, 32'h7FFFFF));
      e8   = 8'($urandom_range(1, 250));
      sg   = 1'($urandom_range(0, 1));
      g    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      r    = 1'($urandom_range(0, 1));
      s    = 1'($urandom_range(0, 1));
      ru   = g & (r | s | frac[0]);
      f    = {2'b01, frac} + {24'd0, ru};
      e.res = f[24] ? {sg, 8'(e8 + 8'd1), 23'h000000} : {sg, e8, f[22:0]};
      e.ovf = 1'b0;
      e.unf = 1'b0;
      e.inx = g | r | s;
      e.lat = 3;
      run_op(e, sg, e8, {2'b01, frac}, g, r, s);
      e = sb_q.pop_front();
      checks++;
      if (!obs_ok || obs_res !== e.res || obs_lat != e.lat) begin
        errors++;
        $display("FAIL b2b_result[%0d]: valid=%b result=%h lat=%0d required 1/%h/%0d",
                 i, obs_ok, obs_res, obs_lat, e.res, e.lat);
      end
      checks++;
      if ({obs_ovf, obs_unf, obs_inx} !== {e.ovf, e.unf, e.inx}) begin
        errors++;
        $display("FAIL b2b_flags[%0d]: got %b required %b", i, {obs_ovf, obs_unf, obs_inx},
                 {e.ovf, e.unf, e.inx});
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_sign     = 1'b0;
    in_exponent = 8'd0;
    in_sum      = 25'd0;
    in_guard    = 1'b0;
    in_round    = 1'b0;
    in_sticky   = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_table("carry", 0, 1);
    test_table("cancel", 1, 2);
    test_table("rne", 3, 2);
    test_table("overflow", 5, 1);
    test_table("zero", 6, 1);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
Post-addition back end of the single-precision FP adder. It takes the aligned sum from the mantissa adder, plus the guard, round and sticky bits, and normalizes it with an iterative left shift or a one-bit right shift. It then rounds to nearest-even and packs an IEEE-754 32-bit result. It sits after the add/subtract stage and uses a valid/ready handshake on both sides.

Parameters:
SHIFT_STEP, 1, maximum left-shift positions per NORM cycle (1..8).
EXP_W, 8, exponent width.
MANT_W, 23, stored fraction width.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input operands valid
in_ready  output  1  block can accept; equals (state==IDLE)
in_sign  input  1  sign of the sum
in_exponent  input  8  common exponent from alignment (never 0)
in_sum  input  25  bit24 = carry out, bit23 = hidden-one position, bits22:0 = fraction
in_guard  input  1  guard bit
in_round  input  1  round bit
in_sticky  input  1  sticky bit
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_result  output  32  packed {sign, exponent, fraction}
out_overflow  output  1  result saturated to infinity
out_underflow  output  1  result flushed to zero
out_inexact  output  1  any of g/r/s nonzero before rounding

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all working registers 0; out_valid, out_result, and all flags 0; in_ready=1 once in IDLE. Reset mid-operation discards the in-flight value with no output.
- Working registers: mant[24:0], g, r, s, exp[8:0] (9-bit to catch overflow), sign.
- IDLE: on in_valid, capture all inputs.
  - If in_sum==0 and g|r|s==0: load out_result=32'h00000000 (+0 regardless of sign) and go to HOLD.
  - Otherwise go to NORM.
- NORM, single-cycle decisions:
  - mant[24]=1: right shift one place. mant>>=1, g<=mant[0], r<=g, s<=s|r, exp+=1. Go to ROUND.
  - mant[24]=0 and mant[23]=1: go to ROUND.
  - Otherwise: left shift {mant,g,r} by n=min(SHIFT_STEP, leading zeros above bit23), zero-filling; s unchanged; exp-=n. Stay in NORM.
  - If exp-n<=0: out_result={sign,31'b0}, out_underflow=1, inexact=g|r|s. Go to HOLD.
- ROUND:
  - roundup = g & (r | s | mant[0]); frac24 = mant[23:0] + roundup.
  - If frac24 carries out (0x1000000): fraction becomes 0 and exp+=1.
  - If exp>=255: out_result={sign,8'hFF,23'b0}, out_overflow=1. Otherwise out_result={sign,exp[7:0],frac[22:0]}.
  - out_inexact=g|r|s. Go to HOLD.
- HOLD: out_valid=1; out_result and flags stay stable until out_ready. On out_valid&&out_ready go to IDLE, clear out_valid, and leave flags held until the next load. No new input is accepted before IDLE.
- Latency, input accepted at edge T:
  - Zero: out_valid at T+1.
  - Normalized or carry case: out_valid at T+3.
  - k-bit left shift: out_valid at T+3+ceil(k/SHIFT_STEP).
- in_exponent==255 on input is illegal; behaviour is undefined.

Optional Feature:
FPNR_FAST_LZC_EN:
- Defined: NORM computes the full leading-zero count with a priority encoder and shifts all positions in one cycle. All non-zero cases give out_valid at T+3, and SHIFT_STEP is ignored.
- Undefined: iterative SHIFT_STEP shifting as described in Behaviour.
- Results are bit-identical either way; only latency differs.

Decomposition:
- Shared package fp_pkg holds:
  - state enum {IDLE, NORM, ROUND, HOLD}
  - EXP_MAX=8'hFF, MANT_W=23, EXP_W=8
  - packed struct fp32_t {sign, exponent, fraction}
  - qNaN/infinity constants
- One sub-module, fp_lzc: 25-bit leading-zero counter returning a 5-bit count, instantiated only under FPNR_FAST_LZC_EN.

Test Plan:
1. Carry case (1.0+1.0): in_sum=25'h1000000, exp=127, g=r=s=0 -> out_result=32'h40000000, inexact=0, out_valid at T+3.
2. Cancellation: in_sum=25'h0000001, exp=127, SHIFT_STEP=1 -> 32'h34000000 at T+26. With exp=10 instead -> 32'h00000000 with out_underflow=1.
3. RNE: in_sum=25'h0800001, g=1, r=s=0 -> 32'h3F800002. Same input with in_sum=25'h0800000 -> 32'h3F800000, inexact=1.
4. Overflow: in_sum=25'h1FFFFFF, exp=254, g=1, sign=1 -> 32'hFF800000, out_overflow=1.
5. Zero: in_sum=0, g=r=s=0, sign=1 -> 32'h00000000 at T+1.
6. Backpressure and reset:
   - out_ready=0 for 5 cycles -> out_result stable, in_ready=0.
   - reset asserted mid-NORM -> out_valid=0 immediately; after release in_ready=1 and a following op completes correctly.
